// File: rtl/fpu_sequencer.sv
// fpu_sequencer: accepts one request at a time, runs it through a strobe/ack FPU and returns result, tag, error and latency.
module fpu_sequencer #(
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [4:0]       req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [4:0]       resp_tag,
  output logic             resp_err,
  output logic [CYC_W-1:0] resp_cycles,
  output logic [3:0]       fpu_op,
  output logic [31:0]      fpu_in1,
  output logic [31:0]      fpu_in2,
  output logic             fpu_in1_stb,
  output logic             fpu_in2_stb,
  input  logic             fpu_in1_ack,
  input  logic             fpu_in2_ack,
  input  logic [31:0]      fpu_out,
  input  logic             fpu_out_stb,
  output logic             fpu_out_ack,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT, ACK, RESP} state_t;
  state_t state, state_nxt;
  logic accept, legal, acks_done, counting;
  logic [CYC_W-1:0] cnt, cnt_inc;
  assign legal = req_op[3:2] == 2'b00;
  assign accept = state == IDLE && req_valid;
  // a strobe already dropped counts as acknowledged, so both acks may land in any order or together
  assign acks_done = (!fpu_in1_stb || fpu_in1_ack) && (!fpu_in2_stb || fpu_in2_ack);
  assign counting = state == SEND || state == WAIT || state == ACK;
  assign cnt_inc = &cnt ? cnt : cnt + CYC_W'(1);
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign resp_valid = state == RESP;
  assign fpu_out_ack = state == ACK;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = req_valid ? (legal ? SEND : RESP) : IDLE;
      SEND: state_nxt = acks_done ? WAIT : SEND;
      WAIT: state_nxt = fpu_out_stb ? ACK : WAIT;
      ACK:  state_nxt = RESP;
      RESP: state_nxt = resp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fpu_op      <= '0;
      fpu_in1     <= '0;
      fpu_in2     <= '0;
      fpu_in1_stb <= 1'b0;
      fpu_in2_stb <= 1'b0;
      resp_data   <= '0;
      resp_tag    <= '0;
      resp_err    <= 1'b0;
      resp_cycles <= '0;
      cnt         <= '0;
    end else begin
      if (accept) begin
        fpu_op      <= req_op;
        fpu_in1     <= req_a;
        fpu_in2     <= req_b;
        resp_tag    <= req_tag;
        resp_err    <= !legal;
        fpu_in1_stb <= legal;
        fpu_in2_stb <= legal;
        resp_data   <= '0;
        resp_cycles <= '0;
        cnt         <= '0;
      end
      if (state == SEND) begin
        fpu_in1_stb <= fpu_in1_stb && !fpu_in1_ack;
        fpu_in2_stb <= fpu_in2_stb && !fpu_in2_ack;
      end
      if (counting) cnt <= cnt_inc;
      if (state == WAIT && fpu_out_stb) resp_data <= fpu_out;
      if (state == ACK) resp_cycles <= cnt_inc;
    end
endmodule
